// File: rtl/cla_serial_subtractor_pkg.sv
// Shared constants and types for the iterative carry-look-ahead subtractor.
// Holds the slice width, the FSM state encoding and the index-width helper.
package cla_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_nibble_sub.sv
// Combinational 4-bit carry-look-ahead slice computing a + ~b + ci.
// c3 is the carry into bit 3, used by the top for signed overflow.
module cla_nibble_sub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       c3,
  output logic       co
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic       w_c1;
  logic       w_c2;
  logic       w_c3;

  assign w_g = a & ~b;
  assign w_p = a ^ ~b;

  assign w_c1 = w_g[0] | (w_p[0] & ci);
  assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
  assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & ci);
  assign co   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

  assign s  = w_p ^ {w_c3, w_c2, w_c1, ci};
  assign c3 = w_c3;

endmodule

// File: rtl/cla_serial_subtractor.sv
// Iterative subtractor: diff = a - b - bin, one 4-bit CLA slice per cycle, LSB first.
// Handshake: a transfer happens on an edge where valid and ready are both high.
module cla_serial_subtractor
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic [1:0]       dbg_state
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = clog2(NIB);

  if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_width_check
    $error("cla_serial_subtractor: WIDTH must be a multiple of 4 and >= 8");
  end

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;
  logic               r_ovf;
  logic               r_zero;

  logic [NIB_W-1:0]   w_a_nib;
  logic [NIB_W-1:0]   w_b_nib;
  logic [NIB_W-1:0]   w_s;
  logic               w_c3;
  logic               w_co;
  logic               w_last;
  logic [WIDTH-1:0]   w_acc_next;

  assign w_a_nib = r_a[{r_idx, 2'b00} +: NIB_W];
  assign w_b_nib = r_b[{r_idx, 2'b00} +: NIB_W];
  assign w_last  = (r_idx == IDX_W'(NIB - 1));

  // r_carry is loaded with ~bin on accept, so nibble 0 sees ~bin as carry-in.
  cla_nibble_sub u_slice (
    .a  (w_a_nib),
    .b  (w_b_nib),
    .ci (r_carry),
    .s  (w_s),
    .c3 (w_c3),
    .co (w_co)
  );

  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[{r_idx, 2'b00} +: NIB_W] = w_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_acc   <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= ~bin;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_co;
          if (w_last) begin
            // Result is published only here so diff stays frozen outside DONE.
            r_diff  <= w_acc_next;
            r_bout  <= ~w_co;
            r_ovf   <= w_c3 ^ w_co;
            r_zero  <= (w_acc_next == '0);
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign dbg_state = r_state;

endmodule
